// File: rtl/tl_socket_1n.sv
// tl_socket_1n: TileLink-UL 1-to-N socket.
//
// Routes client A requests to one of N_MGRS managers by address decode and
// merges manager D responses back to the client with a round-robin arbiter.
// Requests that hit no manager are answered locally by an error responder
// with a single denied D beat.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cli_a_*                 client A channel (valid/ready + request fields)
//   cli_d_*                 client D channel (valid/ready + response fields)
//   mgr_a_*                 per-manager A channels, fields flattened N_MGRS*width
//   mgr_d_*                 per-manager D channels, fields flattened N_MGRS*width
module tl_socket_1n #(
    parameter int unsigned               N_MGRS   = 2,
    parameter int unsigned               DATA_W   = 64,
    parameter int unsigned               ADDR_W   = 64,
    parameter int unsigned               SOURCE_W = 4,
    parameter int unsigned               SINK_W   = 4,
    parameter logic [N_MGRS*ADDR_W-1:0]  MGR_BASE = {64'h1000_0000, 64'h0},
    parameter logic [N_MGRS*ADDR_W-1:0]  MGR_MASK = {64'h0FFF_FFFF, 64'h0FFF_FFFF}
) (
    input  logic                         clk,
    input  logic                         rst_n,

    // Client A
    input  logic                         cli_a_valid_i,
    output logic                         cli_a_ready_o,
    input  logic [2:0]                   cli_a_opcode_i,
    input  logic [2:0]                   cli_a_param_i,
    input  logic [3:0]                   cli_a_size_i,
    input  logic [SOURCE_W-1:0]          cli_a_source_i,
    input  logic [ADDR_W-1:0]            cli_a_address_i,
    input  logic [7:0]                   cli_a_mask_i,
    input  logic [DATA_W-1:0]            cli_a_data_i,
    input  logic                         cli_a_corrupt_i,

    // Client D
    output logic                         cli_d_valid_o,
    input  logic                         cli_d_ready_i,
    output logic [2:0]                   cli_d_opcode_o,
    output logic [2:0]                   cli_d_param_o,
    output logic [3:0]                   cli_d_size_o,
    output logic [SOURCE_W-1:0]          cli_d_source_o,
    output logic [SINK_W-1:0]            cli_d_sink_o,
    output logic                         cli_d_denied_o,
    output logic [DATA_W-1:0]            cli_d_data_o,
    output logic                         cli_d_corrupt_o,

    // Manager A
    output logic [N_MGRS-1:0]            mgr_a_valid_o,
    input  logic [N_MGRS-1:0]            mgr_a_ready_i,
    output logic [N_MGRS*3-1:0]          mgr_a_opcode_o,
    output logic [N_MGRS*3-1:0]          mgr_a_param_o,
    output logic [N_MGRS*4-1:0]          mgr_a_size_o,
    output logic [N_MGRS*SOURCE_W-1:0]   mgr_a_source_o,
    output logic [N_MGRS*ADDR_W-1:0]     mgr_a_address_o,
    output logic [N_MGRS*8-1:0]          mgr_a_mask_o,
    output logic [N_MGRS*DATA_W-1:0]     mgr_a_data_o,
    output logic [N_MGRS-1:0]            mgr_a_corrupt_o,

    // Manager D
    input  logic [N_MGRS-1:0]            mgr_d_valid_i,
    output logic [N_MGRS-1:0]            mgr_d_ready_o,
    input  logic [N_MGRS*3-1:0]          mgr_d_opcode_i,
    input  logic [N_MGRS*3-1:0]          mgr_d_param_i,
    input  logic [N_MGRS*4-1:0]          mgr_d_size_i,
    input  logic [N_MGRS*SOURCE_W-1:0]   mgr_d_source_i,
    input  logic [N_MGRS*SINK_W-1:0]     mgr_d_sink_i,
    input  logic [N_MGRS-1:0]            mgr_d_denied_i,
    input  logic [N_MGRS*DATA_W-1:0]     mgr_d_data_i,
    input  logic [N_MGRS-1:0]            mgr_d_corrupt_i
);

    // Requester N_MGRS on the D side is the local error responder.
    localparam int unsigned      NREQ    = N_MGRS + 1;
    localparam int unsigned      PTR_W   = $clog2(NREQ);
    localparam logic [PTR_W-1:0] ERR_IDX = PTR_W'(N_MGRS);

    localparam logic [2:0] OP_GET        = 3'd4;
    localparam logic [2:0] OP_ACK        = 3'd0;
    localparam logic [2:0] OP_ACK_DATA   = 3'd1;

    typedef enum logic {ErrIdle, ErrResp} err_state_e;

    // ------------------------------------------------------------------
    // A channel: decode and route
    // ------------------------------------------------------------------
    logic [N_MGRS-1:0] a_sel_oh;
    logic              a_hit;

    // Lowest-index matching manager wins when windows overlap.
    always_comb begin
        a_sel_oh = '0;
        a_hit    = 1'b0;
        for (int unsigned j = 0; j < N_MGRS; j++) begin
            if (!a_hit &&
                ((cli_a_address_i & ~MGR_MASK[j*ADDR_W +: ADDR_W]) ==
                 (MGR_BASE[j*ADDR_W +: ADDR_W] & ~MGR_MASK[j*ADDR_W +: ADDR_W]))) begin
                a_sel_oh[j] = 1'b1;
                a_hit       = 1'b1;
            end
        end
    end

    err_state_e err_state_q, err_state_d;
    logic       err_a_ready;
    logic       miss_fire;

    assign err_a_ready = (err_state_q == ErrIdle);
    assign miss_fire   = cli_a_valid_i & ~a_hit & err_a_ready;

    assign mgr_a_valid_o   = {N_MGRS{cli_a_valid_i}} & a_sel_oh;
    assign cli_a_ready_o   = a_hit ? |(mgr_a_ready_i & a_sel_oh) : err_a_ready;

    assign mgr_a_opcode_o  = {N_MGRS{cli_a_opcode_i}};
    assign mgr_a_param_o   = {N_MGRS{cli_a_param_i}};
    assign mgr_a_size_o    = {N_MGRS{cli_a_size_i}};
    assign mgr_a_source_o  = {N_MGRS{cli_a_source_i}};
    assign mgr_a_address_o = {N_MGRS{cli_a_address_i}};
    assign mgr_a_mask_o    = {N_MGRS{cli_a_mask_i}};
    assign mgr_a_data_o    = {N_MGRS{cli_a_data_i}};
    assign mgr_a_corrupt_o = {N_MGRS{cli_a_corrupt_i}};

    // ------------------------------------------------------------------
    // Error responder
    // ------------------------------------------------------------------
    logic [2:0]          err_opcode_q, err_opcode_d;
    logic [3:0]          err_size_q, err_size_d;
    logic [SOURCE_W-1:0] err_source_q, err_source_d;
    logic                err_d_valid;
    logic                err_d_ready;

    assign err_d_valid = (err_state_q == ErrResp);

    always_comb begin
        err_state_d  = err_state_q;
        err_opcode_d = err_opcode_q;
        err_size_d   = err_size_q;
        err_source_d = err_source_q;
        unique case (err_state_q)
            ErrIdle: begin
                if (miss_fire) begin
                    err_state_d  = ErrResp;
                    err_size_d   = cli_a_size_i;
                    err_source_d = cli_a_source_i;
                    err_opcode_d = (cli_a_opcode_i == OP_GET) ? OP_ACK_DATA : OP_ACK;
                end
            end
            ErrResp: begin
                if (err_d_ready) begin
                    err_state_d = ErrIdle;
                end
            end
            default: err_state_d = ErrIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_state_q  <= ErrIdle;
            err_opcode_q <= '0;
            err_size_q   <= '0;
            err_source_q <= '0;
        end else begin
            err_state_q  <= err_state_d;
            err_opcode_q <= err_opcode_d;
            err_size_q   <= err_size_d;
            err_source_q <= err_source_d;
        end
    end

    // ------------------------------------------------------------------
    // D channel: round-robin arbiter with grant lock
    // ------------------------------------------------------------------
    logic [NREQ-1:0]  req_valid;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] rr_idx;
    logic             rr_found;
    logic [PTR_W-1:0] gnt;
    logic             gnt_valid;
    logic             d_fire;
    int unsigned      idx;

    assign req_valid = {err_d_valid, mgr_d_valid_i};

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'(idx);
            end
        end
    end

    // A beat offered while the client stalls keeps its grant, so the D
    // fields cannot change under a stalled client.
    assign gnt       = lock_q ? lock_idx_q : rr_idx;
    assign gnt_valid = rst_n & (lock_q ? req_valid[lock_idx_q] : rr_found);
    assign d_fire    = gnt_valid & cli_d_ready_i;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (d_fire) begin
            lock_d = 1'b0;
            ptr_d  = (gnt == ERR_IDX) ? '0 : gnt + PTR_W'(1);
        end else if (gnt_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign err_d_ready = d_fire & (gnt == ERR_IDX);

    always_comb begin
        mgr_d_ready_o = '0;
        for (int unsigned j = 0; j < N_MGRS; j++) begin
            mgr_d_ready_o[j] = d_fire & (gnt == PTR_W'(j));
        end
    end

    // D field mux; all-zero when nothing is offered.
    always_comb begin
        cli_d_valid_o   = gnt_valid;
        cli_d_opcode_o  = '0;
        cli_d_param_o   = '0;
        cli_d_size_o    = '0;
        cli_d_source_o  = '0;
        cli_d_sink_o    = '0;
        cli_d_denied_o  = 1'b0;
        cli_d_data_o    = '0;
        cli_d_corrupt_o = 1'b0;
        if (gnt_valid) begin
            if (gnt == ERR_IDX) begin
                cli_d_opcode_o  = err_opcode_q;
                cli_d_size_o    = err_size_q;
                cli_d_source_o  = err_source_q;
                cli_d_denied_o  = 1'b1;
                cli_d_corrupt_o = (err_opcode_q == OP_ACK_DATA);
            end else begin
                for (int unsigned j = 0; j < N_MGRS; j++) begin
                    if (gnt == PTR_W'(j)) begin
                        cli_d_opcode_o  = mgr_d_opcode_i[j*3 +: 3];
                        cli_d_param_o   = mgr_d_param_i[j*3 +: 3];
                        cli_d_size_o    = mgr_d_size_i[j*4 +: 4];
                        cli_d_source_o  = mgr_d_source_i[j*SOURCE_W +: SOURCE_W];
                        cli_d_sink_o    = mgr_d_sink_i[j*SINK_W +: SINK_W];
                        cli_d_denied_o  = mgr_d_denied_i[j];
                        cli_d_data_o    = mgr_d_data_i[j*DATA_W +: DATA_W];
                        cli_d_corrupt_o = mgr_d_corrupt_i[j];
                    end
                end
            end
        end
    end

endmodule
